// File: rtl/spi_frame_receiver.sv
// ============================================================================
// Module   : spi_frame_receiver
// Purpose  : SPI mode-0 receiver; synchronizes pins, assembles 16-bit frames
//            and forwards write frames over a single-entry valid/ready buffer.
// Options  : SPI_ADDR_FILTER_EN rejects write addresses above MAX_ADDR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       ncs_i,
    input  logic       copi_i,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_EVAL  = 2'd2
    } state_t;

    localparam logic [4:0] c_frame_bits = 5'd16;
    localparam logic [4:0] c_count_sat  = 5'd17;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("spi_frame_receiver: SYNC_STAGES must be >= 2");
        end
        if (MAX_ADDR < 0 || MAX_ADDR > 127) begin : g_bad_max_addr
            $error("spi_frame_receiver: MAX_ADDR must fit in 7 bits");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic                   r_sclk_prev;
    logic                   r_ncs_prev;

    logic        w_sclk_rise;
    logic        w_ncs_fall;
    logic        w_ncs_rise;
    logic        w_copi;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_shift;
    logic [4:0]  r_count;

    logic        w_eval;
    logic        w_full_len;
    logic        w_write;
    logic        w_addr_bad;
    logic        w_load;

    // nCS idles high, so its synchronizer resets high to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_ncs_sync  <= '1;
            r_copi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_ncs_prev  <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs_i};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi_i};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_ncs_prev  <= r_ncs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
    assign w_ncs_fall  = ~r_ncs_sync[SYNC_STAGES-1] & r_ncs_prev;
    assign w_ncs_rise  = r_ncs_sync[SYNC_STAGES-1] & ~r_ncs_prev;
    assign w_copi      = r_copi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_ncs_fall) w_state_next = S_SHIFT;
            S_SHIFT: if (w_ncs_rise) w_state_next = S_EVAL;
            S_EVAL:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (r_state == S_IDLE && w_ncs_fall) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (r_state == S_SHIFT && w_sclk_rise) begin
            r_shift <= {r_shift[14:0], w_copi};
            if (r_count != c_count_sat) begin
                r_count <= r_count + 5'd1;
            end
        end
    end

    assign w_eval     = (r_state == S_EVAL);
    assign w_full_len = (r_count == c_frame_bits);
    assign w_write    = w_eval && w_full_len && r_shift[15];

`ifdef SPI_ADDR_FILTER_EN
    localparam logic [6:0] c_max_addr = 7'(MAX_ADDR);
    assign w_addr_bad = (r_shift[14:8] > c_max_addr);
`else
    assign w_addr_bad = 1'b0;
`endif

    assign w_load    = w_write && !w_addr_bad;
    assign frame_err = w_eval && (((r_count != 5'd0) && !w_full_len) ||
                                  (w_write && w_addr_bad));
    assign busy      = (r_state == S_SHIFT);

    // A load into a full buffer only succeeds if the old entry leaves this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            overflow <= 1'b0;
        end else if (w_load) begin
            if (!wr_valid || wr_ready) begin
                wr_valid <= 1'b1;
                wr_addr  <= r_shift[14:8];
                wr_data  <= r_shift[7:0];
            end else begin
                overflow <= 1'b1;
            end
        end else if (wr_valid && wr_ready) begin
            wr_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire
